grant_batch_sequencer: RTL



---
 rtl/grant_batch_sequencer_pkg.sv | 30 +++
 rtl/grant_batch_sequencer_cl_grant.sv | 16 +
 rtl/grant_batch_sequencer.sv | 68 ++++++
 3 files changed

// File: rtl/grant_batch_sequencer_pkg.sv
// grant_batch_sequencer_pkg: shared state encoding and index helpers
package grant_batch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int MAX_WIDTH = 64;

  // Bits needed to encode an index into an n-wide vector, never below 1
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) w = i + 1;
    return w;
  endfunction

  // Binary position of the set bit in a one-hot vector; 0 for all-zero input
  function automatic int unsigned encode(input logic [MAX_WIDTH-1:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < MAX_WIDTH; i++)
      if (oh[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/grant_batch_sequencer_cl_grant.sv
// grant_batch_sequencer_cl_grant: combinational lowest-index priority grant
module grant_batch_sequencer_cl_grant #(
  parameter int DATA_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] i_req,
  output logic [DATA_WIDTH-1:0] o_grant,
  output logic                  o_pmt_finish
);

  // Two's-complement trick isolates the lowest set bit
  always_comb begin
    o_grant      = i_req & (~i_req + DATA_WIDTH'(1));
    o_pmt_finish = |i_req;
  end

endmodule

// File: rtl/grant_batch_sequencer.sv
// grant_batch_sequencer: batches request pulses and issues one-hot grants over valid/ready
module grant_batch_sequencer
  import grant_batch_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int IDX_WIDTH  = idx_width(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_req,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_grant,
  output logic [IDX_WIDTH-1:0]  o_idx,
  output logic                  o_batch_done,
  output logic                  o_busy
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic [DATA_WIDTH-1:0] batch_q, batch_d;
  logic [DATA_WIDTH-1:0] g;
  logic [DATA_WIDTH-1:0] remain;
  logic                  pmt_finish;
  logic                  load;

  grant_batch_sequencer_cl_grant #(.DATA_WIDTH(DATA_WIDTH)) u_cl_grant (
    .i_req        (batch_q),
    .o_grant      (g),
    .o_pmt_finish (pmt_finish)
  );

  // Next-state: batch loads only from IDLE/DONE; new requests only ever land in pend
  always_comb begin
    remain  = batch_q & ~g;
    load    = (state_q == IDLE || state_q == DONE) && pend_q != '0;
    pend_d  = (pend_q & ~(load ? pend_q : '0)) | i_req;
    batch_d = load ? pend_q : (state_q == ISSUE && i_ready) ? remain : batch_q;
    state_d = IDLE;
    if (state_q == ISSUE)
      state_d = (i_ready && remain == '0) ? DONE : ISSUE;
    else if (load)
      state_d = ISSUE;
  end

  // Outputs decode registered state only, so nothing combinational from i_req or i_ready
  always_comb begin
    o_valid      = state_q == ISSUE && pmt_finish;
    o_grant      = o_valid ? g : '0;
    o_idx        = o_valid ? IDX_WIDTH'(encode(MAX_WIDTH'(g))) : '0;
    o_batch_done = state_q == DONE;
    o_busy       = state_q != IDLE;
  end

  // State registers; reset discards any batch and pending requests
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      batch_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      batch_q <= batch_d;
    end
  end

endmodule
